// File: rtl/lfsr_pkg.sv
// Shared encodings for the LFSR demo serial link (transmitter and receiver).
// SHIFT_SERIALIZER_PARITY_EN lengthens each frame by one even-parity bit.
package lfsr_pkg;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_SHIFT = 1'b1;

    localparam int DEFAULT_DEPTH = 4;

    function automatic int frame_len(input int depth);
`ifdef SHIFT_SERIALIZER_PARITY_EN
        return depth + 1;
`else
        return depth;
`endif
    endfunction

endpackage

// File: rtl/shift_serializer_frame_bit_counter.sv
// Bit position counter for one serial frame; last flags position FRAME-1.
// Frame length follows SHIFT_SERIALIZER_PARITY_EN through the FRAME parameter.
module frame_bit_counter #(
    parameter int FRAME = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clear,
    input  logic                       enable,
    output logic [$clog2(FRAME)-1:0]   count,
    output logic                       last
);
    localparam int CW = $clog2(FRAME);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable) begin
            count_d = count_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;
    assign last  = (count_q == CW'(FRAME - 1));

endmodule

// File: rtl/shift_serializer.sv
// Parallel-in, serial-out transmitter: DEPTH-bit word out MSB first, one bit per clk.
// SHIFT_SERIALIZER_PARITY_EN appends an even-parity bit to every frame.
//
// state    | meaning
// ST_IDLE  | no frame in flight, Q=0, ready for a word
// ST_SHIFT | driving frame bits on Q, ready again on the last bit
module shift_serializer
    import lfsr_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [DEPTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             Q,
    output logic             q_valid,
    output logic             word_done
);
    localparam int FRAME = frame_len(DEPTH);
    localparam int CW    = $clog2(FRAME);

    logic [0:0]       state_q, state_d;
    logic [FRAME-1:0] sr_q, sr_d;
    logic [FRAME-1:0] frame_word;
    logic [CW-1:0]    cnt;
    logic             cnt_last;
    logic             last_bit;
    logic             accept;

    // Parity rides at the bottom of the shifter so it leaves right after the data.
`ifdef SHIFT_SERIALIZER_PARITY_EN
    assign frame_word = {din, ^din};
`else
    assign frame_word = din;
`endif

    assign last_bit  = (state_q == ST_SHIFT) && cnt_last;
    assign din_ready = rst_n && ((state_q == ST_IDLE) || last_bit);
    assign accept    = din_valid && din_ready;

    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        if (accept) begin
            state_d = ST_SHIFT;
            sr_d    = frame_word;
        end else if (state_q == ST_SHIFT) begin
            sr_d = sr_q << 1;
            if (last_bit) begin
                state_d = ST_IDLE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            sr_q    <= '0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
        end
    end

    frame_bit_counter #(
        .FRAME (FRAME)
    ) u_bit_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (accept || last_bit),
        .enable ((state_q == ST_SHIFT) && !last_bit),
        .count  (cnt),
        .last   (cnt_last)
    );

    assign Q         = (state_q == ST_SHIFT) ? sr_q[FRAME-1] : 1'b0;
    assign q_valid   = (state_q == ST_SHIFT);
    assign word_done = last_bit;

    // The counter must always reload or park; it never runs past the last bit.
    a_cnt_in_range : assert property (@(posedge clk) disable iff (!rst_n) cnt <= CW'(FRAME - 1));

endmodule

// File: tb/tb_shift_serializer.sv
// Scoreboard bench for shift_serializer; honours SHIFT_SERIALIZER_PARITY_EN when defined.
module tb_shift_serializer;
    localparam int DEPTH = 4;
`ifdef SHIFT_SERIALIZER_PARITY_EN
    localparam int FRAME = DEPTH + 1;
`else
    localparam int FRAME = DEPTH;
`endif

    typedef struct packed {
        logic             b;
        logic             last;
        logic [DEPTH-1:0] word;
    } exp_t;

    logic             clk;
    logic             rst_n;
    logic [DEPTH-1:0] din;
    logic             din_valid;
    logic             din_ready;
    logic             Q;
    logic             q_valid;
    logic             word_done;

    exp_t             exp_q[$];
    logic [FRAME-1:0] rx;
    logic             rx_pending;
    logic [DEPTH-1:0] rx_word;
    int               errors;
    int               checks;

    shift_serializer #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .din       (din),
        .din_valid (din_valid),
        .din_ready (din_ready),
        .Q         (Q),
        .q_valid   (q_valid),
        .word_done (word_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference frame: data MSB first, then optional even parity of the word.
    function automatic void push_frame(input logic [DEPTH-1:0] w);
        exp_t e;
        int   ones;
        ones = 0;
        for (int i = 0; i < DEPTH; i++) begin
            e.b    = ((w >> (DEPTH - 1 - i)) & 1) != 0;
            e.last = (i == FRAME - 1);
            e.word = w;
            exp_q.push_back(e);
            ones += int'(w[i]);
        end
`ifdef SHIFT_SERIALIZER_PARITY_EN
        e.b    = (ones % 2) == 1;
        e.last = 1'b1;
        e.word = w;
        exp_q.push_back(e);
`endif
    endfunction

    // Loopback receiver: shifts Q in only while q_valid.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) rx <= '0;
        else if (q_valid) rx <= {rx[FRAME-2:0], Q};
    end

    always @(negedge clk) begin
        exp_t e;
        logic exp_rdy;
        if (!rst_n) begin
            exp_q.delete();
            rx_pending = 1'b0;
            chk("rst_q_valid", 32'(q_valid), 0);
            chk("rst_Q", 32'(Q), 0);
            chk("rst_word_done", 32'(word_done), 0);
            chk("rst_din_ready", 32'(din_ready), 0);
        end else begin
            exp_rdy = (exp_q.size() == 0) || exp_q[0].last;
            chk("din_ready", 32'(din_ready), 32'(exp_rdy));
            if (rx_pending) begin
                chk("loopback", 32'(rx[FRAME-1 -: DEPTH]), 32'(rx_word));
                rx_pending = 1'b0;
            end
            if (exp_q.size() == 0) begin
                chk("idle_q_valid", 32'(q_valid), 0);
                chk("idle_Q", 32'(Q), 0);
                chk("idle_word_done", 32'(word_done), 0);
            end else begin
                e = exp_q.pop_front();
                chk("q_valid", 32'(q_valid), 1);
                chk("Q_bit", 32'(Q), 32'(e.b));
                chk("word_done", 32'(word_done), 32'(e.last));
                if (e.last) begin
                    rx_pending = 1'b1;
                    rx_word    = e.word;
                end
            end
            if (din_valid && exp_rdy) push_frame(din);
        end
    end

    task automatic send(input logic [DEPTH-1:0] w, input bit hold);
        bit ok;
        ok        = 1'b0;
        din       = w;
        din_valid = 1'b1;
        for (int n = 0; n < 3 * FRAME && !ok; n++) begin
            @(negedge clk);
            ok = din_ready;
            @(posedge clk);
            #1;
        end
        chk("send_accepted", 32'(ok), 1);
        if (!hold) begin
            din_valid = 1'b0;
            din       = DEPTH'($urandom);
        end
    endtask

    initial begin
        errors     = 0;
        checks     = 0;
        rx_pending = 1'b0;
        rst_n      = 1'b0;
        din        = '0;
        din_valid  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("cold_Q", 32'(Q), 0);
        chk("cold_q_valid", 32'(q_valid), 0);
        chk("cold_din_ready", 32'(din_ready), 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        send(4'b1011, 1'b0);
        repeat (FRAME + 2) @(posedge clk);
        #1;

        send(4'b1011, 1'b1);
        send(4'b0110, 1'b0);
        repeat (FRAME + 2) @(posedge clk);
        #1;

        send(4'b1111, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_Q", 32'(Q), 0);
        chk("midrst_q_valid", 32'(q_valid), 0);
        chk("midrst_din_ready", 32'(din_ready), 0);
        chk("midrst_word_done", 32'(word_done), 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        send(4'b0001, 1'b0);
        repeat (FRAME + 2) @(posedge clk);
        #1;

        din_valid = 1'b0;
        repeat (10) begin
            @(posedge clk);
            #1;
            din = DEPTH'($urandom);
        end

        // Word in flight while din churns and valid is never offered.
        send(4'b1001, 1'b0);
        repeat (FRAME + 1) begin
            @(posedge clk);
            #1;
            din = DEPTH'($urandom);
        end

        repeat (500) begin
            @(posedge clk);
            #1;
            rst_n     = ($urandom_range(0, 99) != 0);
            din       = DEPTH'($urandom);
            din_valid = ($urandom_range(0, 3) != 0);
        end

        rst_n     = 1'b1;
        din_valid = 1'b0;
        repeat (3 * FRAME) @(posedge clk);
        @(negedge clk);
        #1;
        chk("drained", 32'(exp_q.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
